sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO, next generation of the team's synchronous FIFO.
- Adds:
  - non-power-of-2 depth
  - selectable standard or first-word-fall-through (FWFT) read mode
  - programmable almost-full and almost-empty flags
  - occupancy output
  - sticky overflow and underflow error flags
  - synchronous flush
  - correct simultaneous read/write, including a write while full.
- Sits between producer and consumer stages in the same clock domain.

Parameters:
- Width, 8, data word width in bits (>=1).
- Depth, 10, number of storage entries (>=2, any integer, not restricted to powers of 2).
- AF_Thresh, Depth-2, Almost_Full asserts when count >= AF_Thresh (1..Depth).
- AE_Thresh, 2, Almost_Empty asserts when count <= AE_Thresh (0..Depth-1).
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  synchronous clear of contents; pointers and count only.
- clr_err  in  1  clears Overflow and Underflow.
- data_in  in  Width  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request (pop).
- data_out  out  Width  read data.
- data_valid  out  1  data_out holds a newly popped word (standard mode only).
- Full  out  1  count == Depth.
- Empty  out  1  count == 0.
- Almost_Full  out  1  count >= AF_Thresh.
- Almost_Empty  out  1  count <= AE_Thresh.
- count  out  $clog2(Depth+1)  current occupancy.
- Overflow  out  1  sticky: write attempted and rejected.
- Underflow  out  1  sticky: read attempted while Empty.

Behaviour:
- Reset (reset==0 at a clock edge):
  - wr_ptr, rd_ptr, count = 0.
  - data_out = 0, data_valid = 0, Overflow = 0, Underflow = 0.
  - Storage array is not cleared.
  - Reset has priority over flush, clr_err, wr_en and rd_en.
  - Reset mid-operation discards all contents; the first cycle after reset deassertion behaves as an empty FIFO.
- Flush (reset==1, flush==1):
  - Pointers and count go to 0; data_valid goes to 0.
  - data_out holds its value; error flags are unaffected.
  - wr_en and rd_en in the same cycle are ignored and do not set error flags.
- Accept rules (evaluated on pre-edge state):
  - rd_acc = rd_en && !Empty.
  - wr_acc = wr_en && (!Full || rd_acc).
  - A write while full is accepted only when a read is accepted in the same cycle.
  - A read while empty is never accepted, even with a simultaneous write; there is no bypass.
- Pointer and count update:
  - Each pointer advances by 1 on accept and wraps Depth-1 -> 0 explicitly, not by natural overflow.
  - count += 1 on wr_acc only.
  - count -= 1 on rd_acc only.
  - count is unchanged when both are accepted.
- Flags:
  - Full, Empty, Almost_Full and Almost_Empty are combinational decodes of the registered count.
- Standard mode (FWFT=0):
  - On rd_acc, data_out <= mem[rd_ptr] and data_valid <= 1 at the same edge. Read latency is 1 cycle.
  - data_valid is 0 on any cycle without rd_acc.
  - data_out holds its last value when no read is accepted.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally whenever !Empty; it is 0 when Empty.
  - rd_en pops the displayed word.
  - A written word is visible on data_out the cycle after the write edge.
  - data_valid is tied to !Empty.
- Errors:
  - Overflow <= 1 when wr_en && !wr_acc.
  - Underflow <= 1 when rd_en && Empty.
  - Both flags are sticky until reset or clr_err.
  - If clr_err coincides with a new error, the set wins.
- Width rules:
  - Pointers are $clog2(Depth) bits wide.
  - count is $clog2(Depth+1) bits wide.
  - count never exceeds Depth or goes below 0 under any stimulus.

Decomposition:
- Shared package fifo_pkg holds:
  - function clog2_safe (returns 1 for a depth of 1)
  - localparam mode encodings FIFO_STD=0 and FIFO_FWFT=1.
- Sub-module fifo_ram: Width x Depth storage array with one synchronous write port and one asynchronous read port, instantiated once.
- Control, pointers, count, flags and output register live in sync_fifo_param.

Test Plan:
- Basic ordering: Depth=10, FWFT=0. Write 0x01..0x0A, then read 10 times -> data_out = 0x01..0x0A in order, each one cycle after rd_en. Full high after the 10th write; Empty high after the 10th read; Overflow and Underflow stay 0.
- Wrap-around: Depth=10. Interleave 25 writes and reads, never exceeding 4 entries -> pointers wrap 9->0 twice; output sequence matches input exactly; count peaks at 4.
- Full with simultaneous read/write: fill to Full, then assert wr_en=1 (0xAA) and rd_en=1 together -> both accepted, count stays 10, Overflow=0. Next cycle assert wr_en only -> write rejected, Overflow=1 and held until clr_err pulses.
- Empty errors: with the FIFO empty, assert rd_en together with wr_en (0x55) -> read rejected, Underflow=1, count=1. In FWFT=1 mode, data_out=0x55 on the following cycle.
- Thresholds: AF_Thresh=8, AE_Thresh=2, write 9 words -> Almost_Empty deasserts when count reaches 3; Almost_Full asserts when count reaches 8 and stays high at 9.
- Flush and reset: hold 5 entries and pulse flush -> count=0, Empty=1, data_valid=0, error flags unchanged. Then assert reset=0 during a write burst -> all outputs reach their reset values at the next edge, and no write is accepted in that cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: read-mode encodings and
// a pointer-width helper that stays legal for degenerate depths.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // $clog2(1) is 0, which would give a zero-width pointer.
    function automatic int clog2_safe(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for sync_fifo_param; master drives requests,
// slave (the FIFO) returns data, flags, occupancy and error status.
interface sync_fifo_param_if #(
    parameter int Width = 8,
    parameter int Depth = 10
);
    localparam int CntW = $clog2(Depth + 1);

    // wr_en/rd_en are requests, not valid/ready pairs: a write is taken when
    // wr_en && (!Full || read taken), a read when rd_en && !Empty, both in the
    // same cycle the request is high; a refused request sets the sticky error.
    logic             flush;
    logic             clr_err;
    logic [Width-1:0] data_in;
    logic             wr_en;
    logic             rd_en;
    logic [Width-1:0] data_out;
    logic             data_valid;
    logic             Full;
    logic             Empty;
    logic             Almost_Full;
    logic             Almost_Empty;
    logic [CntW-1:0]  count;
    logic             Overflow;
    logic             Underflow;

    modport master (
        output flush, clr_err, data_in, wr_en, rd_en,
        input  data_out, data_valid, Full, Empty, Almost_Full, Almost_Empty,
               count, Overflow, Underflow
    );

    modport slave (
        input  flush, clr_err, data_in, wr_en, rd_en,
        output data_out, data_valid, Full, Empty, Almost_Full, Almost_Empty,
               count, Overflow, Underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// Width x Depth storage: one synchronous write port, one asynchronous read
// port. Contents are never cleared; validity is tracked by the controller.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int Width = 8,
    parameter int Depth = 10,
    localparam int PtrW = clog2_safe(Depth)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PtrW-1:0]  wr_addr,
    input  logic [Width-1:0] wr_data,
    input  logic [PtrW-1:0]  rd_addr,
    output logic [Width-1:0] rd_data
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with arbitrary depth, standard or first-word-fall-through
// read, programmable almost flags, occupancy and sticky error reporting.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int Width     = 8,
    parameter int Depth     = 10,
    parameter int AF_Thresh = Depth - 2,
    parameter int AE_Thresh = 2,
    parameter int FWFT      = FIFO_STD
) (
    input  logic             clk,
    input  logic             reset,
    sync_fifo_param_if.slave bus
);

    localparam int PtrW = clog2_safe(Depth);
    localparam int CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(Depth);
    localparam logic [CntW-1:0] CntAf   = CntW'(AF_Thresh);
    localparam logic [CntW-1:0] CntAe   = CntW'(AE_Thresh);

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [Width-1:0] dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             full, empty;
    logic             rd_acc, wr_acc;
    logic             ram_we;
    logic [Width-1:0] ram_rd;

    // Explicit wrap so non-power-of-two depths never address past the array.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full   = (count_q == CntMax);
        empty  = (count_q == '0);
        rd_acc = bus.rd_en && !empty && !bus.flush;
        wr_acc = bus.wr_en && (!full || rd_acc) && !bus.flush;
        ram_we = wr_acc && reset;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        dvalid_d = rd_acc;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
            if (wr_acc && !rd_acc) count_d = count_q + 1'b1;
            if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
        end

        if (rd_acc) dout_d = ram_rd;

        // A fresh error outranks a clear in the same cycle.
        if (bus.clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (!bus.flush && bus.wr_en && !wr_acc) ovf_d = 1'b1;
        if (!bus.flush && bus.rd_en && empty)   udf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_ram #(
        .Width (Width),
        .Depth (Depth)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.data_in),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd)
    );

    assign bus.data_out     = (FWFT == FIFO_FWFT) ? (empty ? '0 : ram_rd) : dout_q;
    assign bus.data_valid   = (FWFT == FIFO_FWFT) ? !empty : dvalid_q;
    assign bus.Full         = full;
    assign bus.Empty        = empty;
    assign bus.Almost_Full  = (count_q >= CntAf);
    assign bus.Almost_Empty = (count_q <= CntAe);
    assign bus.count        = count_q;
    assign bus.Overflow     = ovf_q;
    assign bus.Underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus and
// checks both against a queue-based model of the FIFO rules.
module tb_sync_fifo_param;
    import fifo_pkg::*;

    localparam int W     = 8;
    localparam int DEPTH = 10;
    localparam int AF    = 8;
    localparam int AE    = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         flush = 1'b0;
    logic         clr_err = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_dout = '0;
    bit           m_dv = 0;
    bit           m_ovf = 0;
    bit           m_udf = 0;

    // Clock / reset block
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, required finish before it");
        $fatal(1);
    end

    sync_fifo_param_if #(.Width(W), .Depth(DEPTH)) if_std ();
    sync_fifo_param_if #(.Width(W), .Depth(DEPTH)) if_fw ();

    assign if_std.flush = flush;   assign if_fw.flush = flush;
    assign if_std.clr_err = clr_err; assign if_fw.clr_err = clr_err;
    assign if_std.data_in = data_in; assign if_fw.data_in = data_in;
    assign if_std.wr_en = wr_en;   assign if_fw.wr_en = wr_en;
    assign if_std.rd_en = rd_en;   assign if_fw.rd_en = rd_en;

    sync_fifo_param #(.Width(W), .Depth(DEPTH), .AF_Thresh(AF), .AE_Thresh(AE),
                      .FWFT(FIFO_STD)) dut_std (
        .clk(clk), .reset(reset), .bus(if_std.slave));

    sync_fifo_param #(.Width(W), .Depth(DEPTH), .AF_Thresh(AF), .AE_Thresh(AE),
                      .FWFT(FIFO_FWFT)) dut_fw (
        .clk(clk), .reset(reset), .bus(if_fw.slave));

    // Model: one clock edge of FIFO behaviour from the current inputs.
    task automatic model_step();
        bit emp, ful, racc, wacc;
        if (!reset) begin
            exp_q.delete();
            m_dout = '0; m_dv = 0; m_ovf = 0; m_udf = 0;
        end else if (flush) begin
            exp_q.delete();
            m_dv = 0;
            if (clr_err) begin m_ovf = 0; m_udf = 0; end
        end else begin
            emp  = (exp_q.size() == 0);
            ful  = (exp_q.size() == DEPTH);
            racc = rd_en && !emp;
            wacc = wr_en && (!ful || racc);
            if (clr_err) begin m_ovf = 0; m_udf = 0; end
            if (wr_en && !wacc) m_ovf = 1;
            if (rd_en && emp) m_udf = 1;
            m_dv = racc;
            if (racc) m_dout = exp_q.pop_front();
            if (wacc) exp_q.push_back(data_in);
        end
    endtask

    function automatic logic [W-1:0] fw_head();
        return (exp_q.size() != 0) ? exp_q[0] : '0;
    endfunction

    // Driver tasks
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit w, input logic [W-1:0] d, input bit r);
        wr_en = w; data_in = d; rd_en = r; flush = 0; clr_err = 0;
    endtask

    task automatic idle();
        drive(0, '0, 0);
    endtask

    task automatic test_reset();
        reset = 0; idle(); tick(); tick();
        tests_run++;
        if (if_std.count !== '0 || if_std.Empty !== 1'b1 || if_std.Full !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_count: count=%0d empty=%b full=%b, required 0/1/0",
                     if_std.count, if_std.Empty, if_std.Full);
        end
        tests_run++;
        if (if_std.data_out !== '0 || if_std.data_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_dout: data_out=%h valid=%b, required 00/0",
                     if_std.data_out, if_std.data_valid);
        end
        tests_run++;
        if (if_std.Overflow !== 1'b0 || if_std.Underflow !== 1'b0 ||
            if_fw.Overflow !== 1'b0 || if_fw.Underflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_err: ovf=%b udf=%b, required 0/0", if_std.Overflow, if_std.Underflow);
        end
        tests_run++;
        if (if_fw.data_out !== '0 || if_fw.data_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_fwft: data_out=%h valid=%b, required 00/0",
                     if_fw.data_out, if_fw.data_valid);
        end
        reset = 1;
    endtask

    task automatic test_basic_order();
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1, W'(i), 0); tick();
        end
        idle();
        tests_run++;
        if (if_std.Full !== 1'b1 || if_std.count !== CW'(DEPTH)) begin
            tests_failed++;
            $display("FAIL basic_full: full=%b count=%0d, required 1/%0d", if_std.Full, if_std.count, DEPTH);
        end
        for (int i = 1; i <= DEPTH; i++) begin
            tests_run++;
            if (if_fw.data_out !== W'(i)) begin
                tests_failed++;
                $display("FAIL basic_fwft_head: got %h, required %h", if_fw.data_out, W'(i));
            end
            drive(0, '0, 1); tick();
            tests_run++;
            if (if_std.data_out !== W'(i) || if_std.data_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL basic_read: got %h valid=%b, required %h valid=1",
                         if_std.data_out, if_std.data_valid, W'(i));
            end
        end
        idle(); tick();
        tests_run++;
        if (if_std.Empty !== 1'b1 || if_std.data_valid !== 1'b0 || if_std.data_out !== W'(DEPTH)) begin
            tests_failed++;
            $display("FAIL basic_empty: empty=%b valid=%b dout=%h, required 1/0/%h",
                     if_std.Empty, if_std.data_valid, if_std.data_out, W'(DEPTH));
        end
        tests_run++;
        if (if_std.Overflow !== 1'b0 || if_std.Underflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_err: ovf=%b udf=%b, required 0/0", if_std.Overflow, if_std.Underflow);
        end
    endtask

    task automatic test_wrap();
        int written = 0;
        int read_n = 0;
        int peak = 0;
        int cycles = 0;
        bit w, r;
        logic [W-1:0] head;
        while (read_n < 25 && cycles < 500) begin
            cycles++;
            if (written < 4) w = 1;
            else w = (written < 25) && (exp_q.size() < 4) && ($urandom_range(0, 1) == 1);
            r = (written >= 4) && (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
            head = fw_head();
            drive(w, W'($urandom_range(0, 255)), r);
            if (w) written++;
            tick();
            if (r) begin
                read_n++;
                tests_run++;
                if (if_std.data_out !== head || if_std.data_valid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL wrap_read: got %h valid=%b, required %h valid=1",
                             if_std.data_out, if_std.data_valid, head);
                end
            end
            if (int'(if_std.count) > peak) peak = int'(if_std.count);
        end
        idle();
        tests_run++;
        if (read_n != 25) begin
            tests_failed++;
            $display("FAIL wrap_budget: %0d reads done, required 25", read_n);
        end
        tests_run++;
        if (peak != 4) begin
            tests_failed++;
            $display("FAIL wrap_peak: count peaked at %0d, required 4", peak);
        end
    endtask

    task automatic test_full_rw();
        logic [W-1:0] head;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, W'($urandom_range(0, 255)), 0); tick();
        end
        head = fw_head();
        drive(1, 8'hAA, 1); tick();
        tests_run++;
        if (if_std.count !== CW'(DEPTH) || if_std.Overflow !== 1'b0 || if_std.data_out !== head) begin
            tests_failed++;
            $display("FAIL full_rw: count=%0d ovf=%b dout=%h, required %0d/0/%h",
                     if_std.count, if_std.Overflow, if_std.data_out, DEPTH, head);
        end
        drive(1, 8'h11, 0); tick();
        tests_run++;
        if (if_std.Overflow !== 1'b1 || if_fw.Overflow !== 1'b1 || if_std.count !== CW'(DEPTH)) begin
            tests_failed++;
            $display("FAIL full_ovf: ovf=%b count=%0d, required 1/%0d", if_std.Overflow, if_std.count, DEPTH);
        end
        idle(); tick(); tick();
        tests_run++;
        if (if_std.Overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_sticky: got %b, required 1", if_std.Overflow);
        end
        clr_err = 1; tick(); clr_err = 0;
        tests_run++;
        if (if_std.Overflow !== 1'b0 || if_fw.Overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_clear: got %b, required 0", if_std.Overflow);
        end
        for (int i = 0; i < DEPTH; i++) begin
            head = fw_head();
            drive(0, '0, 1); tick();
            tests_run++;
            if (if_std.data_out !== head) begin
                tests_failed++;
                $display("FAIL full_drain: got %h, required %h", if_std.data_out, head);
            end
        end
        idle();
        tests_run++;
        if (if_std.data_out !== 8'hAA || if_std.Empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_last: dout=%h empty=%b, required aa/1", if_std.data_out, if_std.Empty);
        end
    endtask

    task automatic test_empty_err();
        drive(1, 8'h55, 1); tick(); idle();
        tests_run++;
        if (if_std.Underflow !== 1'b1 || if_fw.Underflow !== 1'b1 || if_std.count !== CW'(1)) begin
            tests_failed++;
            $display("FAIL empty_udf: udf=%b count=%0d, required 1/1", if_std.Underflow, if_std.count);
        end
        tests_run++;
        if (if_std.data_valid !== 1'b0 || if_fw.data_out !== 8'h55 || if_fw.data_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL empty_fwft: std_valid=%b fw_dout=%h fw_valid=%b, required 0/55/1",
                     if_std.data_valid, if_fw.data_out, if_fw.data_valid);
        end
        clr_err = 1; tick(); clr_err = 0;
        drive(0, '0, 1); tick(); idle();
        tests_run++;
        if (if_std.data_out !== 8'h55 || if_std.Underflow !== 1'b0 || if_std.Empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL empty_pop: dout=%h udf=%b empty=%b, required 55/0/1",
                     if_std.data_out, if_std.Underflow, if_std.Empty);
        end
    endtask

    task automatic test_thresholds();
        for (int n = 1; n <= 9; n++) begin
            drive(1, W'(n + 8'h30), 0); tick();
            tests_run++;
            if (if_std.Almost_Empty !== (n <= AE) || if_std.Almost_Full !== (n >= AF) ||
                if_std.count !== CW'(n)) begin
                tests_failed++;
                $display("FAIL thresh_n%0d: ae=%b af=%b count=%0d, required %b/%b/%0d",
                         n, if_std.Almost_Empty, if_std.Almost_Full, if_std.count, n <= AE, n >= AF, n);
            end
        end
        idle();
    endtask

    task automatic test_flush_reset();
        logic [W-1:0] held;
        drive(1, 8'h3A, 0); tick();
        drive(1, 8'h3B, 0); tick();
        for (int i = 0; i < 5; i++) begin drive(0, '0, 1); tick(); end
        held = m_dout;
        flush = 1; wr_en = 1; rd_en = 1; data_in = 8'hEE; tick(); idle();
        tests_run++;
        if (if_std.count !== '0 || if_std.Empty !== 1'b1 || if_std.data_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_state: count=%0d empty=%b valid=%b, required 0/1/0",
                     if_std.count, if_std.Empty, if_std.data_valid);
        end
        tests_run++;
        if (if_std.Overflow !== 1'b1 || if_std.Underflow !== 1'b0 || if_std.data_out !== held) begin
            tests_failed++;
            $display("FAIL flush_keep: ovf=%b udf=%b dout=%h, required 1/0/%h",
                     if_std.Overflow, if_std.Underflow, if_std.data_out, held);
        end
        for (int i = 0; i < 3; i++) begin drive(1, W'(8'h60 + i), 0); tick(); end
        reset = 0; drive(1, 8'h99, 0); tick();
        tests_run++;
        if (if_std.count !== '0 || if_std.data_out !== '0 || if_std.Overflow !== 1'b0 ||
            if_fw.data_out !== '0 || if_std.Empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL burst_reset: count=%0d dout=%h ovf=%b fw_dout=%h, required 0/00/0/00",
                     if_std.count, if_std.data_out, if_std.Overflow, if_fw.data_out);
        end
        reset = 1; idle(); tick();
        drive(1, 8'h77, 0); tick();
        drive(0, '0, 1); tick(); idle();
        tests_run++;
        if (if_std.data_out !== 8'h77 || if_std.Empty !== 1'b1 || if_std.Underflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset: dout=%h empty=%b udf=%b, required 77/1/0",
                     if_std.data_out, if_std.Empty, if_std.Underflow);
        end
    endtask

    task automatic test_random();
        int sz;
        for (int c = 0; c < 400; c++) begin
            int wp = (c < 200) ? 65 : 35;
            drive($urandom_range(0, 99) < wp, W'($urandom_range(0, 255)), $urandom_range(0, 99) >= wp);
            flush   = ($urandom_range(0, 39) == 0);
            clr_err = ($urandom_range(0, 19) == 0);
            tick();
            sz = exp_q.size();
            tests_run++;
            if (if_std.count !== CW'(sz) || if_fw.count !== CW'(sz) || if_std.Full !== (sz == DEPTH) ||
                if_std.Empty !== (sz == 0) || if_std.Almost_Full !== (sz >= AF) ||
                if_std.Almost_Empty !== (sz <= AE)) begin
                tests_failed++;
                $display("FAIL rand_occ c%0d: count=%0d F=%b E=%b AF=%b AE=%b, required count=%0d",
                         c, if_std.count, if_std.Full, if_std.Empty, if_std.Almost_Full,
                         if_std.Almost_Empty, sz);
            end
            tests_run++;
            if (if_std.data_out !== m_dout || if_std.data_valid !== m_dv) begin
                tests_failed++;
                $display("FAIL rand_std c%0d: dout=%h valid=%b, required %h/%b",
                         c, if_std.data_out, if_std.data_valid, m_dout, m_dv);
            end
            tests_run++;
            if (if_fw.data_out !== fw_head() || if_fw.data_valid !== (sz != 0)) begin
                tests_failed++;
                $display("FAIL rand_fwft c%0d: dout=%h valid=%b, required %h/%b",
                         c, if_fw.data_out, if_fw.data_valid, fw_head(), sz != 0);
            end
            tests_run++;
            if (if_std.Overflow !== m_ovf || if_std.Underflow !== m_udf ||
                if_fw.Overflow !== m_ovf || if_fw.Underflow !== m_udf) begin
                tests_failed++;
                $display("FAIL rand_err c%0d: ovf=%b udf=%b, required %b/%b",
                         c, if_std.Overflow, if_std.Underflow, m_ovf, m_udf);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_wrap();
        test_full_rw();
        test_empty_err();
        test_thresholds();
        test_flush_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
